// File: rtl/lag_marker_overlay.sv
// Overlays three centred black/white marker boxes on a video stream and flags
// flash frames and frame starts for the lag tester's LED and photo-sensor reference.
module lag_marker_overlay #(
    parameter int H_RES        = 1280,
    parameter int V_RES        = 720,
    parameter int BOX_W        = 256,
    parameter int BOX_H        = 120,
    parameter int DARK_FRAMES  = 30,
    parameter int FLASH_FRAMES = 30,
    parameter bit VS_POL       = 1'b1
) (
    input  logic       clk_pixel,
    input  logic       hdmi_rstn,
    input  logic       I_enable,
    input  logic       I_vs,
    input  logic       I_hs,
    input  logic       I_de,
    input  logic [7:0] I_r,
    input  logic [7:0] I_g,
    input  logic [7:0] I_b,
    output logic       O_vs,
    output logic       O_hs,
    output logic       O_de,
    output logic [7:0] O_r,
    output logic [7:0] O_g,
    output logic [7:0] O_b,
    output logic       O_flash,
    output logic       O_frame_start
);

    if (DARK_FRAMES < 1 || DARK_FRAMES > 256 || FLASH_FRAMES < 1 || FLASH_FRAMES > 256) begin : g_bad_frames
        $error("lag_marker_overlay: DARK_FRAMES and FLASH_FRAMES must be in 1..256");
    end

    localparam logic [11:0] X_LO       = 12'((H_RES - BOX_W) / 2);
    localparam logic [11:0] X_HI       = 12'((H_RES - BOX_W) / 2 + BOX_W);
    localparam logic [10:0] Y_TOP_HI   = 11'(BOX_H);
    localparam logic [10:0] Y_MID_LO   = 11'((V_RES - BOX_H) / 2);
    localparam logic [10:0] Y_MID_HI   = 11'((V_RES - BOX_H) / 2 + BOX_H);
    localparam logic [10:0] Y_BOT_LO   = 11'(V_RES - BOX_H);
    localparam logic [10:0] Y_BOT_HI   = 11'(V_RES);
    localparam logic [7:0]  DARK_LAST  = 8'(DARK_FRAMES - 1);
    localparam logic [7:0]  FLASH_LAST = 8'(FLASH_FRAMES - 1);

    typedef enum logic {DARK = 1'b0, FLASH = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [7:0]  frame_cnt, frame_cnt_nxt;
    logic        en_latch, en_nxt;
    logic        vs_act, vs_act_prev, frame_start, de_prev;
    logic [11:0] x_cnt;
    logic [10:0] y_cnt;
    logic        hit, flash_nxt;
    logic [7:0]  r_nxt, g_nxt, b_nxt;

    assign vs_act      = ~(I_vs ^ VS_POL);
    assign frame_start = vs_act & ~vs_act_prev;

    // x holds the position of the current DE pixel; y counts completed active lines.
    always_ff @(posedge clk_pixel or negedge hdmi_rstn) begin
        if (!hdmi_rstn) begin
            vs_act_prev <= 1'b0;
            de_prev     <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
        end else begin
            vs_act_prev <= vs_act;
            de_prev     <= I_de;
            if (!I_de)
                x_cnt <= '0;
            else if (x_cnt != 12'hFFF)
                x_cnt <= x_cnt + 12'd1;
            if (frame_start)
                y_cnt <= '0;
            else if (de_prev && !I_de && y_cnt != 11'h7FF)
                y_cnt <= y_cnt + 11'd1;
        end
    end

    always_ff @(posedge clk_pixel or negedge hdmi_rstn) begin
        if (!hdmi_rstn) begin
            state     <= DARK;
            frame_cnt <= '0;
            en_latch  <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_cnt_nxt;
            en_latch  <= en_nxt;
        end
    end

    // All sequencing happens at frame boundaries; a fresh or dropped enable restarts in DARK.
    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        en_nxt        = en_latch;
        if (frame_start) begin
            en_nxt = I_enable;
            if (!I_enable || !en_latch) begin
                state_nxt     = DARK;
                frame_cnt_nxt = '0;
            end else begin
                unique case (state)
                    DARK: begin
                        if (frame_cnt == DARK_LAST) begin
                            state_nxt     = FLASH;
                            frame_cnt_nxt = '0;
                        end else begin
                            frame_cnt_nxt = frame_cnt + 8'd1;
                        end
                    end
                    FLASH: begin
                        if (frame_cnt == FLASH_LAST) begin
                            state_nxt     = DARK;
                            frame_cnt_nxt = '0;
                        end else begin
                            frame_cnt_nxt = frame_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state_nxt     = DARK;
                        frame_cnt_nxt = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        hit = (x_cnt >= X_LO) && (x_cnt < X_HI) &&
              ((y_cnt < Y_TOP_HI) ||
               ((y_cnt >= Y_MID_LO) && (y_cnt < Y_MID_HI)) ||
               ((y_cnt >= Y_BOT_LO) && (y_cnt < Y_BOT_HI)));
        flash_nxt = (state_nxt == FLASH) && en_nxt;
        r_nxt     = I_r;
        g_nxt     = I_g;
        b_nxt     = I_b;
        if (I_de && en_latch && hit) begin
            r_nxt = (state == FLASH) ? 8'hFF : 8'h00;
            g_nxt = (state == FLASH) ? 8'hFF : 8'h00;
            b_nxt = (state == FLASH) ? 8'hFF : 8'h00;
        end
    end

    always_ff @(posedge clk_pixel or negedge hdmi_rstn) begin
        if (!hdmi_rstn) begin
            O_vs          <= 1'b0;
            O_hs          <= 1'b0;
            O_de          <= 1'b0;
            O_r           <= '0;
            O_g           <= '0;
            O_b           <= '0;
            O_flash       <= 1'b0;
            O_frame_start <= 1'b0;
        end else begin
            O_vs          <= I_vs;
            O_hs          <= I_hs;
            O_de          <= I_de;
            O_r           <= r_nxt;
            O_g           <= g_nxt;
            O_b           <= b_nxt;
            O_flash       <= flash_nxt;
            O_frame_start <= frame_start;
        end
    end

endmodule

// File: doc/lag_marker_overlay.md
Name: lag_marker_overlay

Overview:
Video-stream stage between the test-pattern generator and the HDMI/DVI serializer in the lag-tester top. It overlays three centred marker boxes (top, middle, bottom of the active image) that alternate between black and white on whole-frame boundaries. It also emits a flash-state flag and a frame-start pulse for the LED and external photo-sensor timing reference. All video signals pass through with a fixed 1-cycle latency.

Parameters:
H_RES, 1280, active pixels per line
V_RES, 720, active lines per frame
BOX_W, 256, marker box width in pixels
BOX_H, 120, marker box height in lines
DARK_FRAMES, 30, frames the boxes stay black per cycle (>=1)
FLASH_FRAMES, 30, frames the boxes stay white per cycle (>=1)
VS_POL, 1, 1 = vsync active-high, 0 = active-low

Ports:
clk_pixel  in  1  pixel clock
hdmi_rstn  in  1  reset, asynchronous, active-low
I_enable  in  1  overlay enable, level; sampled only at frame start
I_vs  in  1  vsync from pattern generator
I_hs  in  1  hsync from pattern generator
I_de  in  1  data enable from pattern generator
I_r  in  8  red in
I_g  in  8  green in
I_b  in  8  blue in
O_vs  out  1  I_vs delayed 1 cycle
O_hs  out  1  I_hs delayed 1 cycle
O_de  out  1  I_de delayed 1 cycle
O_r  out  8  red out, overlay applied
O_g  out  8  green out, overlay applied
O_b  out  8  blue out, overlay applied
O_flash  out  1  1 while current frame is a white (FLASH) frame
O_frame_start  out  1  1-cycle pulse at frame boundary

Behaviour:
- Reset (async assert, sync release): all outputs 0; x, y, frame counters 0; state DARK; enable latch 0.
- Latency: O_vs/O_hs/O_de/O_rgb are registered, exactly 1 clk after the inputs. No other pipeline stages.
- Frame boundary: rising edge of the active-polarity vsync (vs_act = I_vs XNOR VS_POL). Detected from registered previous vs_act. O_frame_start pulses in the cycle whose outputs carry the first vsync-active sample.
- x counter, 12 bits: 0 on the first DE pixel, +1 per DE cycle, cleared when DE is low. Saturates at 4095.
- y counter, 11 bits: +1 on each DE falling edge. Cleared at frame boundary; frame boundary wins over a coincident DE fall. Saturates at 2047.
- Box hit: x in [(H_RES-BOX_W)/2, (H_RES-BOX_W)/2+BOX_W) AND one of:
  - y in [0, BOX_H)
  - y in [(V_RES-BOX_H)/2, (V_RES-BOX_H)/2+BOX_H)
  - y in [V_RES-BOX_H, V_RES)
  Bounds are computed at elaboration. Integer division truncates.
- Pixel mux (when DE=1 and enable latch=1):
  - hit in FLASH: rgb = FF,FF,FF
  - hit in DARK: rgb = 00,00,00
  - otherwise: input rgb passes through unchanged.
- When DE=0: rgb output = input (pass-through); no forcing.
- Enable latch: loads I_enable at each frame boundary only, so mid-frame changes never tear a frame. Latch=0 means pure pass-through.
- FSM states: DARK, FLASH. Frame counter counts completed frames in the current state; it advances only at frame boundaries.
  - DARK -> FLASH when counter = DARK_FRAMES-1 at a boundary; counter clears.
  - FLASH -> DARK when counter = FLASH_FRAMES-1; counter clears.
  - Enable latch loads 0: state forced to DARK and counter cleared at that same boundary.
  - Enable latch 0 -> 1: sequence starts at DARK, count 0.
- O_flash = (state==FLASH) AND enable latch; updates in the frame-boundary cycle.
- Frame counter is 8 bits; DARK_FRAMES and FLASH_FRAMES must be <=256 (elaboration check).
- Reset mid-frame: immediate return to reset values. First boundary after release starts a clean DARK frame.

Test Plan:
- 1280x720 timing, I_enable=1, constant input rgb 11,11,11, DARK_FRAMES=FLASH_FRAMES=2:
  - frames 0-1: pixel (640,10) = 00,00,00; frames 2-3: pixel (640,10) = FF,FF,FF; repeats with period 4.
  - pixel (100,10) = 11,11,11 in all frames.
  - O_flash high exactly during frames 2-3.
- Box edges, FLASH frame:
  - x=511,y=0 -> input; x=512,y=0 -> FF; x=767,y=119 -> FF; x=768 or y=120 -> input.
  - y=300 -> FF; y=299 -> input; y=600 -> FF; y=719 -> FF.
- Latency: random rgb/hs/vs/de per cycle -> every output equals its input 1 clk earlier, except box pixels when enabled.
- Toggle I_enable mid-frame (line 360):
  - output of that frame unchanged until next vsync edge.
  - after deassert: pure pass-through, O_flash=0, state DARK.
  - re-assert: 2 dark frames first.
- VS_POL=0 with active-low vsync -> boundary, O_frame_start and y clear on vsync falling edge; one pulse per frame.
- Assert hdmi_rstn low during a FLASH frame -> outputs 0 within the same cycle; after release, first full frame is DARK with y counting from 0.
